// File: rtl/setb_seq_ctrl.sv
// Preset sequencer: drives the active-low SETB of an async-set flop bank for N cycles,
// then holds its capture enable low for GUARD cycles so recovery/removal is always met.
module setb_seq_ctrl #(
   parameter int PW_W  = 4,
   parameter int GUARD = 2
) (
   input  logic            CLK,
   input  logic            RSTB,
   input  logic            REQ,
   input  logic [PW_W-1:0] PW,
   output logic            SETB,
   output logic            CKEN,
   output logic            BUSY,
   output logic            DONE,
   output logic            OVR
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      GUARD_W = 2'd2
   } state_t;

   localparam logic [3:0]      GUARD_L = 4'(GUARD);
   localparam logic [PW_W-1:0] ONE_W   = PW_W'(1);

   state_t          state_reg, state_next;
   logic [PW_W-1:0] width_reg, width_next;
   logic [3:0]      guard_reg, guard_next;
   logic            setb_next, cken_next, busy_next, done_next, ovr_next;

   // State register; outputs are registered alongside so they are glitch-free.
   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state_reg <= IDLE;
         width_reg <= '0;
         guard_reg <= '0;
         SETB      <= 1'b1;
         CKEN      <= 1'b1;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         OVR       <= 1'b0;
      end else begin
         state_reg <= state_next;
         width_reg <= width_next;
         guard_reg <= guard_next;
         SETB      <= setb_next;
         CKEN      <= cken_next;
         BUSY      <= busy_next;
         DONE      <= done_next;
         OVR       <= ovr_next;
      end
   end

   // Counters count down to 1 and never below, so a zero width is promoted to one cycle.
   always_comb begin
      state_next = state_reg;
      width_next = width_reg;
      guard_next = guard_reg;
      case (state_reg)
         IDLE: begin
            if (REQ) begin
               state_next = ASSERT;
               width_next = (PW == '0) ? ONE_W : PW;
            end
         end
         ASSERT: begin
            if (width_reg == ONE_W) begin
               if (GUARD > 0) begin
                  state_next = GUARD_W;
                  guard_next = GUARD_L;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               width_next = width_reg - ONE_W;
            end
         end
         GUARD_W: begin
            if (guard_reg == 4'd1) begin
               state_next = IDLE;
            end else begin
               guard_next = guard_reg - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // CKEN is only high in IDLE, so it can never be high while SETB is low.
   always_comb begin
      setb_next = (state_next != ASSERT);
      cken_next = (state_next == IDLE);
      busy_next = (state_next != IDLE);
      done_next = (state_reg != IDLE) && (state_next == IDLE);
      ovr_next  = OVR | (REQ & BUSY);
   end

endmodule

// File: tb/tb_setb_seq_ctrl.sv
// Bench for setb_seq_ctrl: GUARD=2 and GUARD=0 instances share stimulus; each is
// compared every cycle with a time-since-accept model, plus literal spot checks.
module tb_setb_seq_ctrl;

   logic       clk = 1'b0;
   logic       rstb, req;
   logic [3:0] pw;
   logic       setb [2];
   logic       cken [2];
   logic       busy [2];
   logic       done [2];
   logic       ovr  [2];

   int passed = 0;
   int total  = 0;

   // Model: whether a sequence exists, cycles since its accept edge, its width, sticky flag.
   int m_act [2];
   int m_t   [2];
   int m_n   [2];
   int m_ovr [2];
   int m_g   [2];

   always #5 clk = ~clk;

   setb_seq_ctrl #(.PW_W(4), .GUARD(2)) u_g2 (
      .CLK(clk), .RSTB(rstb), .REQ(req), .PW(pw),
      .SETB(setb[0]), .CKEN(cken[0]), .BUSY(busy[0]), .DONE(done[0]), .OVR(ovr[0])
   );

   setb_seq_ctrl #(.PW_W(4), .GUARD(0)) u_g0 (
      .CLK(clk), .RSTB(rstb), .REQ(req), .PW(pw),
      .SETB(setb[1]), .CKEN(cken[1]), .BUSY(busy[1]), .DONE(done[1]), .OVR(ovr[1])
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic model_update(input int i, input logic r, input logic q, input int p);
      int busy_before;
      if (!r) begin
         m_act[i] = 0;
         m_ovr[i] = 0;
      end else begin
         busy_before = (m_act[i] != 0) && (m_t[i] < m_n[i] + m_g[i]);
         if (q && busy_before) m_ovr[i] = 1;
         if (!busy_before) begin
            if (q) begin
               m_act[i] = 1;
               m_t[i]   = 0;
               m_n[i]   = (p == 0) ? 1 : p;
            end else begin
               m_act[i] = 0;
            end
         end else begin
            m_t[i]++;
         end
      end
   endtask

   task automatic check_all(input int i);
      logic e_setb, e_cken, e_busy, e_done;
      if (m_act[i] == 0) begin
         e_setb = 1'b1; e_cken = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         e_setb = !(m_t[i] < m_n[i]);
         e_cken = !(m_t[i] < m_n[i] + m_g[i]);
         e_busy = (m_t[i] < m_n[i] + m_g[i]);
         e_done = (m_t[i] == m_n[i] + m_g[i]);
      end
      chk($sformatf("g%0d_setb", m_g[i]), setb[i], e_setb);
      chk($sformatf("g%0d_cken", m_g[i]), cken[i], e_cken);
      chk($sformatf("g%0d_busy", m_g[i]), busy[i], e_busy);
      chk($sformatf("g%0d_done", m_g[i]), done[i], e_done);
      chk($sformatf("g%0d_ovr", m_g[i]), ovr[i], logic'(m_ovr[i] != 0));
   endtask

   // One clock: drive inputs, update model at the edge, compare at the falling edge.
   task automatic step(input logic r, input logic q, input int p);
      rstb = r;
      req  = q;
      pw   = 4'(p);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_update(i, r, q, p);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_all(i);
   endtask

   initial begin
      m_g[0] = 2;
      m_g[1] = 0;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_t[i] = 0; m_n[i] = 1; m_ovr[i] = 0;
      end
      rstb = 1'b0; req = 1'b1; pw = 4'd3;

      // Reset with REQ high: nothing may start.
      step(0, 1, 3);
      step(0, 1, 3);
      chk("rst_setb", setb[0], 1'b1);
      chk("rst_busy", busy[0], 1'b0);
      for (int s = 0; s < 7; s++) step(1, 0, 3);

      // Basic: PW=3, GUARD=2.
      step(1, 1, 3);
      chk("basic_setb_k", setb[0], 1'b0);
      step(1, 0, 3);
      step(1, 0, 3);
      chk("basic_setb_k2", setb[0], 1'b0);
      step(1, 0, 3);
      chk("basic_setb_k3", setb[0], 1'b1);
      chk("basic_cken_k3", cken[0], 1'b0);
      step(1, 0, 3);
      chk("basic_cken_k4", cken[0], 1'b0);
      step(1, 0, 3);
      chk("basic_cken_k5", cken[0], 1'b1);
      chk("basic_done_k5", done[0], 1'b1);
      chk("basic_busy_k5", busy[0], 1'b0);
      step(1, 0, 3);
      chk("basic_done_k6", done[0], 1'b0);
      for (int s = 0; s < 3; s++) step(1, 0, 3);

      // PW=0 behaves as a one-cycle pulse.
      step(1, 1, 0);
      chk("pw0_setb_k", setb[0], 1'b0);
      step(1, 0, 0);
      chk("pw0_setb_k1", setb[0], 1'b1);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("pw0_done_k3", done[0], 1'b1);
      for (int s = 0; s < 3; s++) step(1, 0, 0);

      // Overlap: PW=4, PW changes to 9 after accept, second REQ at k+2.
      step(1, 1, 4);
      step(1, 0, 9);
      step(1, 1, 9);
      chk("ovl_ovr_k2", ovr[0], 1'b1);
      step(1, 0, 9);
      step(1, 0, 9);
      chk("ovl_setb_k4", setb[0], 1'b1);
      step(1, 0, 9);
      step(1, 0, 9);
      chk("ovl_done_k6", done[0], 1'b1);
      for (int s = 0; s < 3; s++) step(1, 0, 9);

      // Mid-sequence reset during ASSERT.
      step(1, 1, 5);
      step(0, 0, 5);
      chk("mrst_setb", setb[0], 1'b1);
      chk("mrst_ovr", ovr[0], 1'b0);
      for (int s = 0; s < 8; s++) step(1, 0, 5);

      // GUARD=0 instance, PW=2, REQ held high.
      step(1, 1, 2);
      step(1, 1, 2);
      step(1, 1, 2);
      chk("g0_setb_k2", setb[1], 1'b1);
      chk("g0_cken_k2", cken[1], 1'b1);
      chk("g0_done_k2", done[1], 1'b1);
      step(1, 1, 2);
      chk("g0_reaccept_k3", setb[1], 1'b0);
      chk("g0_ovr_k3", ovr[1], 1'b1);
      for (int s = 0; s < 4; s++) step(1, 0, 2);

      // Randomised traffic with occasional resets.
      for (int s = 0; s < 600; s++) begin
         step(logic'($urandom_range(0, 59) != 0),
              logic'($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/setb_seq_ctrl.md
# setb_seq_ctrl

Synchronous preset sequencer that drives the active-low SETB pin of a bank of async-set D flip-flops, such as the DFFAS family. On a request it asserts SETB for a programmable number of clock cycles. It then holds a capture-enable low for a guard window so the downstream flops' SETB→CLK recovery/removal checks are never violated. It sits directly upstream of the set-flop bank and owns both its SETB and its clock-enable.

## Interface
- PW_W, default 4: width of the pulse-width input.
- GUARD, default 2: cycles CKEN stays low after SETB releases; legal range 0..15.
- CLK  in  1  clock; all state changes on rising edge.
- RSTB  in  1  reset; synchronous, active-low, sampled on rising CLK.
- REQ  in  1  preset request; level-sampled each rising edge.
- PW  in  PW_W  SETB low duration in cycles; latched on accept.
- SETB  out  1  active-low preset to downstream flops; registered.
- CKEN  out  1  capture enable for downstream flops; registered; low = hold.
- BUSY  out  1  sequence in progress; registered.
- DONE  out  1  one-cycle pulse when sequence completes; registered.
- OVR  out  1  sticky: REQ seen while BUSY; cleared only by reset.

## Operation
- Reset (RSTB=0 at a rising edge) produces SETB=1, CKEN=1, BUSY=0, DONE=0, OVR=0 and state IDLE. Reset overrides everything, including a sequence in progress. SETB returns high at that edge; no partial pulse is completed.
- State machine: IDLE, ASSERT, GUARD_W.
- IDLE: REQ=1 → ASSERT.
  - Latch N = (PW==0 ? 1 : PW) into the width counter.
  - Set SETB=0, CKEN=0, BUSY=1.
- ASSERT: the counter decrements each cycle. When it reaches the last cycle:
  - GUARD>0 → GUARD_W, with SETB=1, CKEN=0, and the guard counter loaded with GUARD.
  - GUARD==0 → IDLE, with SETB=1, CKEN=1, BUSY=0, DONE=1.
- GUARD_W: the counter decrements. On the last cycle → IDLE with CKEN=1, BUSY=0, DONE=1.
- DONE is high for exactly one cycle and is 0 otherwise.
- REQ=1 while BUSY=1 is ignored for sequencing and sets OVR=1. OVR stays 1 until reset.
- Changes to PW after accept do not affect the running sequence.
- Counter widths are PW_W bits and 4 bits; no wrap-around is possible because the counters only count down to 1.
- SETB and CKEN are never both driven such that CKEN=1 while SETB=0.

## Timing
- Accept at edge k. Outputs after edge k: SETB=0, CKEN=0, BUSY=1.
- SETB is low for exactly N cycles and rises after edge k+N.
- CKEN rises, BUSY falls and DONE pulses after edge k+N+GUARD.
- DONE falls after edge k+N+GUARD+1.
- Back-to-back: REQ held high continuously is re-accepted at edge k+N+GUARD+1. Minimum period between sequences is N+GUARD+1 cycles.
- REQ high at edge k+N+GUARD (the DONE edge) is still BUSY at sampling and sets OVR.
- Latency from REQ sample to SETB low is 1 edge. All outputs are glitch-free flop outputs.

## Test plan
- Reset: hold RSTB=0 for 2 edges with REQ=1. Required: SETB=1, CKEN=1, BUSY=0, DONE=0, OVR=0, and no sequence starts.
- Basic, PW=3, GUARD=2: REQ pulse at edge 10. Required:
  - SETB=0 after edges 10–12, 1 after edge 13.
  - CKEN=0 after edges 10–14, 1 after edge 15.
  - DONE=1 only after edge 15; BUSY falls after edge 15.
- PW=0: REQ at edge 5. Required: SETB low for exactly 1 cycle (rises after edge 6), DONE after edge 8 (GUARD=2).
- Overlap: PW=4, second REQ at edge k+2. Required: OVR=1 from edge k+2 onward and the sequence timing is unchanged. A PW change to 9 at edge k+1 has no effect.
- Mid-sequence reset: RSTB=0 at edge k+1 during ASSERT. Required after edge k+1: SETB=1, CKEN=1, BUSY=0, DONE=0, and no DONE pulse afterwards.
- GUARD=0 variant, PW=2: REQ held high continuously. Required:
  - SETB and CKEN rise together after edge k+2, with DONE after edge k+2.
  - Next accept at edge k+3.
  - OVR=1, because REQ was high while BUSY.
